// File: rtl/mdu_unit_if.sv
// Bus between the execute stage and the multiply/divide unit.
// Handshake: the requester pulses Start for one cycle with MDUOp/A/B valid;
// the unit accepts a request only while Busy=0, and Busy=1 means an
// operation is in flight and any Start is dropped without effect.
// HI/LO always show the architectural register pair.
interface mdu_unit_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       MDUOp;
    logic             Start;
    logic             Busy;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;
    logic             dbg_run;   // FSM state: 1 = RUN, 0 = IDLE

    modport master (
        output A, B, MDUOp, Start,
        input  Busy, HI, LO, dbg_run
    );

    modport slave (
        input  A, B, MDUOp, Start,
        output Busy, HI, LO, dbg_run
    );
endinterface

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO register pair.
// The full 2*WIDTH result is computed combinationally at the start edge and
// parked in pending registers; a down-counter models the pipeline latency and
// HI/LO are committed on the edge where the counter reaches zero.
module mdu_unit #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic       clk,
    input  logic       reset,
    mdu_unit_if.slave  bus
);

    localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state, state_nx;
    logic [CW-1:0]      count, count_nx;
    logic               accept_arith;
    logic               complete;

    logic [WIDTH-1:0]   hi_q, lo_q;
    logic [WIDTH-1:0]   pend_hi, pend_lo;
    logic               pend_wr;

    // Arithmetic datapath (evaluated on the live operands at the start edge)
    logic [2*WIDTH-1:0] prod_s, prod_u;
    logic               div_zero;
    logic [WIDTH-1:0]   b_safe;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH-1:0]   qs_mag, rs_mag, qs, rs;
    logic [WIDTH-1:0]   qu, ru;
    logic [2*WIDTH-1:0] result;

    // Products: sign-extend to 2*WIDTH for mult, zero-extend for multu
    always_comb begin
        prod_s = $signed({{WIDTH{bus.A[WIDTH-1]}}, bus.A}) *
                 $signed({{WIDTH{bus.B[WIDTH-1]}}, bus.B});
        prod_u = {{WIDTH{1'b0}}, bus.A} * {{WIDTH{1'b0}}, bus.B};
    end

    // Quotients/remainders; a zero divisor is replaced by 1 so the divider
    // never sees zero, and the result is simply not committed later.
    // Signed division works on magnitudes: quotient sign = sign(A)^sign(B),
    // remainder sign = sign(A). The most-negative / -1 case falls out as
    // LO=A, HI=0 because the magnitude wraps back to the same bit pattern.
    always_comb begin
        div_zero = (bus.B == '0);
        b_safe   = div_zero ? WIDTH'(1) : bus.B;
        a_mag    = bus.A[WIDTH-1] ? (~bus.A + WIDTH'(1)) : bus.A;
        b_mag    = b_safe[WIDTH-1] ? (~b_safe + WIDTH'(1)) : b_safe;
        qs_mag   = a_mag / b_mag;
        rs_mag   = a_mag % b_mag;
        qs       = (bus.A[WIDTH-1] ^ b_safe[WIDTH-1]) ? (~qs_mag + WIDTH'(1)) : qs_mag;
        rs       = bus.A[WIDTH-1] ? (~rs_mag + WIDTH'(1)) : rs_mag;
        qu       = bus.A / b_safe;
        ru       = bus.A % b_safe;
    end

    // Select the {HI,LO} image for the requested operation
    always_comb begin
        result = '0;
        case (bus.MDUOp[1:0])
            2'd0:    result = prod_s;
            2'd1:    result = prod_u;
            2'd2:    result = {rs, qs};
            default: result = {ru, qu};
        endcase
    end

    assign accept_arith = (state == IDLE) && bus.Start && !bus.MDUOp[2];

    // Next-state and counter logic
    always_comb begin
        state_nx = state;
        count_nx = count;
        complete = 1'b0;
        case (state)
            IDLE: begin
                if (accept_arith) begin
                    state_nx = RUN;
                    count_nx = bus.MDUOp[1] ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
                end
            end
            RUN: begin
                count_nx = count - CW'(1);
                if (count == CW'(1)) begin
                    state_nx = IDLE;
                    complete = 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                count_nx = '0;
            end
        endcase
    end

    // State register and latency counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_nx;
            count <= count_nx;
        end
    end

    // Capture the pending result and its write-enable at the start edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_hi <= '0;
            pend_lo <= '0;
            pend_wr <= 1'b0;
        end else if (accept_arith) begin
            pend_hi <= result[2*WIDTH-1:WIDTH];
            pend_lo <= result[WIDTH-1:0];
            pend_wr <= !(bus.MDUOp[1] && div_zero);
        end
    end

    // HI/LO update: completion commit, or mthi/mtlo while idle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (complete) begin
            if (pend_wr) begin
                hi_q <= pend_hi;
                lo_q <= pend_lo;
            end
        end else if ((state == IDLE) && bus.Start) begin
            if (bus.MDUOp == 3'd4) begin
                hi_q <= bus.A;
            end else if (bus.MDUOp == 3'd5) begin
                lo_q <= bus.A;
            end
        end
    end

    assign bus.Busy    = (state == RUN);
    assign bus.dbg_run = (state == RUN);
    assign bus.HI      = hi_q;
    assign bus.LO      = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: directed vector table, randomized
// operations against an arithmetic reference model, and hand-written
// sequences for start-while-busy and asynchronous reset mid-operation.
module tb_mdu_unit;

    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;

    mdu_unit_if #(.WIDTH(W)) bus ();

    mdu_unit #(
        .WIDTH      (W),
        .MUL_CYCLES (5),
        .DIV_CYCLES (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Clock
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] m_hi, m_lo;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           cyc;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: plain 64-bit arithmetic on the architectural rules
    task automatic model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         inout logic [W-1:0] hi, inout logic [W-1:0] lo, output int cyc);
        logic signed [63:0] sa, sb, ua, ub, p, q, r;
        sa = 64'($signed(a));
        sb = 64'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        cyc = 0;
        case (op)
            3'd0: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; cyc = 5; end
            3'd1: begin p = ua * ub; hi = p[63:32]; lo = p[31:0]; cyc = 5; end
            3'd2: begin
                cyc = 10;
                if (b != 0) begin q = sa / sb; r = sa % sb; lo = q[31:0]; hi = r[31:0]; end
            end
            3'd3: begin
                cyc = 10;
                if (b != 0) begin q = ua / ub; r = ua % ub; lo = q[31:0]; hi = r[31:0]; end
            end
            3'd4: hi = a;
            3'd5: lo = a;
            default: ;
        endcase
    endtask

    // Driver: one Start pulse, then count Busy cycles while checking HI/LO hold
    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] hold_hi, input logic [W-1:0] hold_lo, output int cyc);
        @(negedge clk);
        bus.MDUOp = op;
        bus.A     = a;
        bus.B     = b;
        bus.Start = 1'b1;
        @(negedge clk);
        bus.Start = 1'b0;
        bus.A     = $urandom;
        bus.B     = $urandom;
        cyc = 0;
        while (bus.Busy && cyc < 100) begin
            check("hold_hi", bus.HI, hold_hi);
            check("hold_lo", bus.LO, hold_lo);
            cyc++;
            @(negedge clk);
        end
        if (cyc >= 100) begin
            n_tests++;
            n_fail++;
            $display("FAIL busy_timeout: Busy still high after %0d cycles", cyc);
        end
    endtask

    initial begin
        int cyc;
        logic [2:0] op;
        logic [W-1:0] a, b, e_hi, e_lo, e_cyc;

        vecs[0]  = '{3'd0, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 5};
        vecs[1]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
        vecs[2]  = '{3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[3]  = '{3'd3, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 10};
        vecs[4]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
        vecs[5]  = '{3'd4, 32'h00001234, 32'h00000000, 32'h00001234, 32'h80000000, 0};
        vecs[6]  = '{3'd5, 32'h00005678, 32'h00000000, 32'h00001234, 32'h00005678, 0};
        vecs[7]  = '{3'd2, 32'h00000005, 32'h00000000, 32'h00001234, 32'h00005678, 10};
        vecs[8]  = '{3'd3, 32'h00000009, 32'h00000000, 32'h00001234, 32'h00005678, 10};
        vecs[9]  = '{3'd6, 32'hAAAAAAAA, 32'h00000001, 32'h00001234, 32'h00005678, 0};
        vecs[10] = '{3'd7, 32'hBBBBBBBB, 32'h00000002, 32'h00001234, 32'h00005678, 0};
        vecs[11] = '{3'd0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 5};

        // Reset
        reset     = 1'b1;
        bus.Start = 1'b0;
        bus.MDUOp = 3'd7;
        bus.A     = '0;
        bus.B     = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_hi", bus.HI, 32'h0);
        check("reset_lo", bus.LO, 32'h0);
        check("reset_busy", {31'b0, bus.Busy}, 32'h0);

        // Directed table
        m_hi = '0;
        m_lo = '0;
        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, m_hi, m_lo, cyc);
            check($sformatf("vec%0d_cycles", i), 32'(cyc), 32'(vecs[i].cyc));
            check($sformatf("vec%0d_hi", i), bus.HI, vecs[i].hi);
            check($sformatf("vec%0d_lo", i), bus.LO, vecs[i].lo);
            m_hi = vecs[i].hi;
            m_lo = vecs[i].lo;
        end

        // Randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] hold_hi, hold_lo;
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = ($urandom_range(0, 7) == 0) ? 32'h0 :
                 ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 20)) : 32'($urandom);
            if ($urandom_range(0, 5) == 0) a = 32'h80000000;
            hold_hi = m_hi;
            hold_lo = m_lo;
            model(op, a, b, m_hi, m_lo, cyc);
            exp_q.push_back(m_hi);
            exp_q.push_back(m_lo);
            exp_q.push_back(32'(cyc));
            run_op(op, a, b, hold_hi, hold_lo, cyc);
            e_hi  = exp_q.pop_front();
            e_lo  = exp_q.pop_front();
            e_cyc = exp_q.pop_front();
            check($sformatf("rnd%0d_op%0d_hi", i, op), bus.HI, e_hi);
            check($sformatf("rnd%0d_op%0d_lo", i, op), bus.LO, e_lo);
            check($sformatf("rnd%0d_op%0d_cycles", i, op), 32'(cyc), e_cyc);
        end

        // Start while busy (mtlo plus operand change) must be ignored
        @(negedge clk);
        bus.MDUOp = 3'd0;
        bus.A     = 32'h00001000;
        bus.B     = 32'h00000030;
        bus.Start = 1'b1;
        @(negedge clk);
        bus.Start = 1'b0;
        cyc = 0;
        while (bus.Busy && cyc < 100) begin
            cyc++;
            if (cyc == 2) begin
                bus.Start = 1'b1;
                bus.MDUOp = 3'd5;
                bus.A     = 32'h0000DEAD;
                bus.B     = 32'h00000077;
            end else begin
                bus.Start = 1'b0;
            end
            @(negedge clk);
        end
        bus.Start = 1'b0;
        check("ignore_cycles", 32'(cyc), 32'd5);
        check("ignore_hi", bus.HI, 32'h00000000);
        check("ignore_lo", bus.LO, 32'h00030000);
        @(negedge clk);
        check("ignore_lo_later", bus.LO, 32'h00030000);

        // Asynchronous reset in the middle of a divide
        run_op(3'd4, 32'h0000AAAA, 32'h0, 32'h0, 32'h0, cyc);
        run_op(3'd5, 32'h0000BBBB, 32'h0, 32'h0, 32'h0, cyc);
        check("pre_reset_hi", bus.HI, 32'h0000AAAA);
        check("pre_reset_lo", bus.LO, 32'h0000BBBB);
        @(negedge clk);
        bus.MDUOp = 3'd2;
        bus.A     = 32'd100;
        bus.B     = 32'd7;
        bus.Start = 1'b1;
        @(negedge clk);
        bus.Start = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_div_busy", {31'b0, bus.Busy}, 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_busy", {31'b0, bus.Busy}, 32'h0);
        check("async_reset_state", {31'b0, bus.dbg_run}, 32'h0);
        check("async_reset_hi", bus.HI, 32'h0);
        check("async_reset_lo", bus.LO, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        check("post_reset_busy", {31'b0, bus.Busy}, 32'h0);
        check("post_reset_hi", bus.HI, 32'h0);
        check("post_reset_lo", bus.LO, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
